// File: rtl/bictr_decode_seq.sv
// Command sequencer for a DW03_bictr_decode style up/down counter.
// Turns LOAD / COUNT_UP / COUNT_DN commands into registered counter strobes and tracks a shadow count.
module bictr_decode_seq #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8,
  localparam int DW = (WIDTH > LEN_W) ? WIDTH : LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [DW-1:0]    cmd_data,
  input  logic             abort,
  output logic             ctr_load,
  output logic             ctr_cen,
  output logic             ctr_up_dwn,
  output logic [WIDTH-1:0] ctr_data,
  input  logic             ctr_carry,
  output logic             done,
  output logic             sts_wrap,
  output logic             sts_abort,
  output logic [WIDTH-1:0] shadow_val
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DN   = 2'b10;

  state_t             state, state_nx;
  logic [LEN_W-1:0]   remain, remain_nx;
  logic               load_nx, cen_nx, up_nx, done_nx, wrap_nx, abort_nx;
  logic [WIDTH-1:0]   data_nx, shadow_nx;
  logic               hs;
  logic               last_step;
  logic [LEN_W-1:0]   n_req;

  assign cmd_ready = (state == ST_IDLE);
  assign hs        = cmd_valid && cmd_ready;
  assign n_req     = cmd_data[LEN_W-1:0];
  assign last_step = (remain == LEN_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      remain     <= '0;
      ctr_load   <= 1'b0;
      ctr_cen    <= 1'b0;
      ctr_up_dwn <= 1'b0;
      ctr_data   <= '0;
      done       <= 1'b0;
      sts_wrap   <= 1'b0;
      sts_abort  <= 1'b0;
      shadow_val <= '0;
    end else begin
      state      <= state_nx;
      remain     <= remain_nx;
      ctr_load   <= load_nx;
      ctr_cen    <= cen_nx;
      ctr_up_dwn <= up_nx;
      ctr_data   <= data_nx;
      done       <= done_nx;
      sts_wrap   <= wrap_nx;
      sts_abort  <= abort_nx;
      shadow_val <= shadow_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (hs) begin
          unique case (cmd_op)
            OP_LOAD:      state_nx = ST_LOAD;
            OP_UP, OP_DN: state_nx = (n_req != '0) ? ST_RUN : ST_DONE;
            default:      state_nx = ST_DONE;
          endcase
        end
      end
      ST_LOAD: state_nx = ST_DONE;
      // The step in the abort cycle still executes; leaving RUN drops cen next cycle.
      ST_RUN:  if (last_step || abort) state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they come straight out of flops.
  always_comb begin
    load_nx   = (state_nx == ST_LOAD);
    cen_nx    = (state_nx == ST_RUN);
    done_nx   = (state_nx == ST_DONE);
    up_nx     = ctr_up_dwn;
    data_nx   = ctr_data;
    remain_nx = remain;
    shadow_nx = shadow_val;
    wrap_nx   = sts_wrap;
    abort_nx  = sts_abort;

    if (hs) begin
      remain_nx = n_req;
      wrap_nx   = 1'b0;
      abort_nx  = 1'b0;
      if (cmd_op == OP_LOAD) data_nx = cmd_data[WIDTH-1:0];
      if (state_nx == ST_RUN) up_nx = (cmd_op == OP_UP);
    end else begin
      if (state == ST_RUN) begin
        remain_nx = remain - LEN_W'(1);
        shadow_nx = ctr_up_dwn ? shadow_val + WIDTH'(1) : shadow_val - WIDTH'(1);
        if (abort && !last_step) abort_nx = 1'b1;
      end
      if (state == ST_LOAD) shadow_nx = ctr_data;
      if (ctr_cen && ctr_carry) wrap_nx = 1'b1;
    end
  end

endmodule

// File: tb/tb_bictr_decode_seq.sv
// Directed bench for bictr_decode_seq with a behavioural up/down counter on the ctr_* pins.
// Expected per-command results are queued at issue time and checked when done pulses.
module tb_bictr_decode_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       abort;
  logic       ctr_load;
  logic       ctr_cen;
  logic       ctr_up_dwn;
  logic [7:0] ctr_data;
  logic       ctr_carry;
  logic       done;
  logic       sts_wrap;
  logic       sts_abort;
  logic [7:0] shadow_val;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] cnt;
  logic [7:0] exp_shadow;

  typedef struct {
    logic [7:0] shadow;
    logic       wrap;
    logic       abrt;
    int         cen;
    int         load;
    int         lat;
  } exp_t;

  exp_t sb[$];

  bictr_decode_seq #(.WIDTH(8), .LEN_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .abort      (abort),
    .ctr_load   (ctr_load),
    .ctr_cen    (ctr_cen),
    .ctr_up_dwn (ctr_up_dwn),
    .ctr_data   (ctr_data),
    .ctr_carry  (ctr_carry),
    .done       (done),
    .sts_wrap   (sts_wrap),
    .sts_abort  (sts_abort),
    .shadow_val (shadow_val)
  );

  always #5 clk = ~clk;

  // Counter under control: carry_out flags the terminal count in the current direction.
  always @(posedge clk or posedge rst) begin
    if (rst)           cnt <= 8'h00;
    else if (ctr_load) cnt <= ctr_data;
    else if (ctr_cen)  cnt <= ctr_up_dwn ? cnt + 8'h01 : cnt - 8'h01;
  end
  assign ctr_carry = ctr_cen && (ctr_up_dwn ? (cnt == 8'hFF) : (cnt == 8'h00));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [7:0] data, input int abort_at);
    exp_t e, g;
    logic [7:0] v;
    int steps, cyc, cen_cnt, load_cnt, rdy_cnt, t;
    bit got_done;
    e.shadow = exp_shadow; e.wrap = 1'b0; e.abrt = 1'b0; e.cen = 0; e.load = 0; e.lat = 1;
    if (op == 2'b00) begin
      e.shadow = data; e.load = 1; e.lat = 2;
    end else if ((op == 2'b01 || op == 2'b10) && data != 8'h00) begin
      steps  = (abort_at > 0 && abort_at < int'(data)) ? abort_at : int'(data);
      e.abrt = (abort_at > 0 && abort_at < int'(data));
      e.cen  = steps;
      e.lat  = steps + 1;
      v = exp_shadow;
      for (int i = 0; i < steps; i++) begin
        if (op == 2'b01 ? (v == 8'hFF) : (v == 8'h00)) e.wrap = 1'b1;
        v = (op == 2'b01) ? v + 8'h01 : v - 8'h01;
      end
      e.shadow = v;
    end
    exp_shadow = e.shadow;
    sb.push_back(e);

    cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
    t = 0;
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    cmd_valid = 1'b0;

    cyc = 0; cen_cnt = 0; load_cnt = 0; rdy_cnt = 0; got_done = 0;
    while (!got_done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cmd_ready) rdy_cnt++;
      if (ctr_load) begin
        load_cnt++;
        check("ctr_data_in_load", ctr_data, data);
      end
      if (ctr_cen) begin
        cen_cnt++;
        if (cen_cnt == 1) check("up_dwn_dir", ctr_up_dwn, op == 2'b01);
        abort = (cen_cnt == abort_at);
      end else begin
        abort = 1'b0;
      end
      if (done) got_done = 1;
    end
    abort = 1'b0;
    check("done_seen", got_done, 1);

    g = sb.pop_front();
    check("done_latency", cyc, g.lat);
    check("cen_cycles", cen_cnt, g.cen);
    check("load_cycles", load_cnt, g.load);
    check("ready_low_while_busy", rdy_cnt, 0);
    check("shadow_val", shadow_val, g.shadow);
    check("shadow_vs_counter", shadow_val, cnt);
    check("sts_wrap", sts_wrap, g.wrap);
    check("sts_abort", sts_abort, g.abrt);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("ready_after_done", cmd_ready, 1);
  endtask

  initial begin
    int dn, rd;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 8'h00; abort = 1'b0;
    exp_shadow = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_load", ctr_load, 0);
    check("rst_cen", ctr_cen, 0);
    check("rst_done", done, 0);
    check("rst_data", ctr_data, 8'h00);
    check("rst_shadow", shadow_val, 8'h00);
    check("rst_status", {sts_wrap, sts_abort, ctr_up_dwn}, 3'b000);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", cmd_ready, 1);

    do_cmd(2'b00, 8'h5A, 0);
    check("count_dec_bit90", cnt, 8'd90);

    do_cmd(2'b00, 8'hFC, 0);
    do_cmd(2'b01, 8'd6, 0);

    do_cmd(2'b00, 8'h03, 0);
    do_cmd(2'b10, 8'd3, 0);
    check("count_dec_bit0", cnt, 8'd0);

    do_cmd(2'b01, 8'd10, 4);
    do_cmd(2'b01, 8'd10, 10);

    do_cmd(2'b01, 8'd0, 0);
    do_cmd(2'b11, 8'h77, 0);
    check("nop_keeps_up_dwn", ctr_up_dwn, 1);

    do_cmd(2'b10, 8'd255, 0);

    // Back-to-back NOPs with cmd_valid held high.
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_data = 8'h00;
    @(posedge clk);
    dn = 0; rd = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) dn++;
      if (cmd_ready) rd++;
      if (done && cmd_ready) check("done_and_ready_overlap", 1, 0);
      if (ctr_cen || ctr_load) check("nop_strobe_activity", 1, 0);
    end
    cmd_valid = 1'b0;
    check("b2b_done_count", dn, 3);
    check("b2b_ready_count", rd, 3);
    check("b2b_shadow", shadow_val, exp_shadow);
    @(negedge clk);

    // Reset in the middle of a COUNT_UP.
    do_cmd(2'b00, 8'hFC, 0);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = 8'd20;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("midrun_cen", ctr_cen, 1);
    check("midrun_wrap", sts_wrap, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_cen", ctr_cen, 0);
    check("async_rst_done", done, 0);
    check("async_rst_status", {sts_wrap, sts_abort}, 2'b00);
    check("async_rst_shadow", shadow_val, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    exp_shadow = 8'h00;
    @(negedge clk);
    check("post_rst_ready", cmd_ready, 1);
    check("post_rst_shadow", shadow_val, 8'h00);
    check("post_rst_cen", ctr_cen, 0);

    do_cmd(2'b01, 8'd2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
